// File: rtl/memoria_datos_param.sv
// memoria_datos_param: byte/half/word data memory with sign/zero-extended loads and a post-reset
// clear sequencer. Optional macro MISALIGN_TRAP_EN traps misaligned accesses instead of aligning down.
module memoria_datos_param #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ad,
   input  logic [DATA_W-1:0] di,
   input  logic              we,
   input  logic              re,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   output logic [DATA_W-1:0] d_o,
   output logic              rvalid,
   output logic              busy,
   output logic              misalign
);

   localparam int         IDX_W   = $clog2(DEPTH);
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_idx;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  word_idx;
   logic [1:0]        lane;
   logic [3:0]        lane_we;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_shift;
   logic [DATA_W-1:0] rd_fmt;
   logic [DATA_W-1:0] rd_data;
   logic              is_ready;
   logic              wr_do;
   logic              unused_ad_hi;

   // Address bits above the word index wrap onto the same storage.
   assign word_idx     = ad[IDX_W+1:2];
   assign unused_ad_hi = ^ad[ADDR_W-1:IDX_W+2];
   assign is_ready     = (state == ST_READY);

   // Lane selection; the low address bits a size cannot use are forced to zero.
   always_comb begin
      lane = 2'b00;
      case (size)
         SZ_BYTE: lane = ad[1:0];
         SZ_HALF: lane = {ad[1], 1'b0};
         default: lane = 2'b00;
      endcase
   end

   always_comb begin
      lane_we = 4'b0000;
      wr_data = di;
      case (size)
         SZ_BYTE: begin
            lane_we = 4'b0001 << lane;
            wr_data = {4{di[7:0]}};
         end
         SZ_HALF: begin
            lane_we = 4'b0011 << lane;
            wr_data = {2{di[15:0]}};
         end
         default: begin
            lane_we = 4'b1111;
            wr_data = di;
         end
      endcase
   end

   assign rd_word  = mem[word_idx];
   assign rd_shift = rd_word >> {lane, 3'b000};

   always_comb begin
      rd_fmt = rd_word;
      case (size)
         SZ_BYTE: rd_fmt = {{24{sign_ext & rd_shift[7]}}, rd_shift[7:0]};
         SZ_HALF: rd_fmt = {{16{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
         default: rd_fmt = rd_word;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic mis;

   always_comb begin
      mis = 1'b0;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = ad[0];
         default: mis = |ad[1:0];
      endcase
   end

   assign wr_do   = is_ready & we & ~mis;
   assign rd_data = mis ? '0 : rd_fmt;
`else
   assign wr_do    = is_ready & we;
   assign rd_data  = rd_fmt;
   assign misalign = 1'b0;
`endif

   // Storage has no reset; the clear sequencer zeroes it one word per cycle.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (wr_do) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Read handshake: a read sampled with re=1 in READY yields rvalid=1 for exactly the next cycle
   // with d_o carrying the formatted (pre-write) word; d_o holds its value while rvalid=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         clr_idx  <= '0;
         busy     <= 1'b1;
         d_o      <= '0;
         rvalid   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign <= 1'b0;
`endif
      end else begin
         rvalid <= 1'b0;
         case (state)
            ST_CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == IDX_W'(DEPTH - 1)) begin
                  state <= ST_READY;
                  busy  <= 1'b0;
               end
            end
            ST_READY: begin
               if (re) begin
                  d_o    <= rd_data;
                  rvalid <= 1'b1;
               end
`ifdef MISALIGN_TRAP_EN
               if (we | re) misalign <= mis;
`endif
            end
            default: begin
               state <= ST_CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memoria_datos_param.sv
// tb_memoria_datos_param: randomized and directed load/store traffic against a byte-array model;
// read data is checked by a monitor popping an expected queue whenever rvalid is seen.
module tb_memoria_datos_param;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 256;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] ad;
   logic [DATA_W-1:0] di;
   logic              we;
   logic              re;
   logic [1:0]        size;
   logic              sign_ext;
   logic [DATA_W-1:0] d_o;
   logic              rvalid;
   logic              busy;
   logic              misalign;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [7:0]        model_b [DEPTH*4];
   logic              exp_mis;

   memoria_datos_param #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ad       (ad),
      .di       (di),
      .we       (we),
      .re       (re),
      .size     (size),
      .sign_ext (sign_ext),
      .d_o      (d_o),
      .rvalid   (rvalid),
      .busy     (busy),
      .misalign (misalign)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      if (sz == 2'b00) return 1;
      if (sz == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
      return (a % 32'(nbytes(sz))) != 0;
   endfunction

   // Byte address in the model of the first byte touched (aligned down to the access size).
   function automatic int base_byte(input logic [31:0] a, input logic [1:0] sz);
      int word;
      int off;
      word = int'((a / 4) % DEPTH);
      off  = int'(a % 4);
      off  = off - (off % nbytes(sz));
      return word * 4 + off;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input logic sx);
      logic [31:0] v;
      int n;
      int b;
      n = nbytes(sz);
      b = base_byte(a, sz);
      v = '0;
`ifdef MISALIGN_TRAP_EN
      if (is_mis(a, sz)) return '0;
`endif
      for (int k = 0; k < n; k++) v = v | (32'(model_b[b+k]) << (8*k));
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      int n;
      int b;
      logic [31:0] t;
      n = nbytes(sz);
      b = base_byte(a, sz);
`ifdef MISALIGN_TRAP_EN
      if (is_mis(a, sz)) return;
`endif
      for (int k = 0; k < n; k++) begin
         t = d >> (8*k);
         model_b[b+k] = t[7:0];
      end
   endtask

   task automatic model_zero();
      for (int i = 0; i < DEPTH*4; i++) model_b[i] = 8'h00;
      exp_mis = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every rvalid pops one expected load result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected: got rvalid=1 d_o=0x%08h expected no read result", d_o);
         end else begin
            check("load_data", d_o, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sx);
      we       = w;
      re       = r;
      ad       = a;
      di       = d;
      size     = sz;
      sign_ext = sx;
      // The load sees the contents before a same-cycle store.
      if (r) exp_q.push_back(model_load(a, sz, sx));
      if (w) model_store(a, sz, d);
`ifdef MISALIGN_TRAP_EN
      if (w | r) exp_mis = is_mis(a, sz);
`endif
      @(negedge clk);
      we = 1'b0;
      re = 1'b0;
      check("misalign", 32'(misalign), 32'(exp_mis));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Releases reset and counts busy cycles; we/re are held active to show they are ignored.
   task automatic run_clear(input string tag);
      int n;
      @(negedge clk);
      rst_n = 1'b1;
      we    = 1'b1;
      re    = 1'b1;
      ad    = $urandom();
      di    = $urandom();
      size  = 2'b10;
      n     = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (busy === 1'b1 && n < 1000);
      we = 1'b0;
      re = 1'b0;
      check({tag, "_clear_cycles"}, 32'(n), 32'(DEPTH));
      model_zero();
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [1:0]  sz;

      rst_n    = 1'b0;
      we       = 1'b0;
      re       = 1'b0;
      ad       = '0;
      di       = '0;
      size     = 2'b00;
      sign_ext = 1'b0;
      exp_mis  = 1'b0;
      model_zero();

      repeat (3) @(negedge clk);
      check("reset_d_o", d_o, 32'h0);
      check("reset_rvalid", 32'(rvalid), 32'h0);
      check("reset_busy", 32'(busy), 32'h1);
      check("reset_misalign", 32'(misalign), 32'h0);

      run_clear("init");

      // Dump every word back to back.
      for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i*4), 32'h0, 2'b10, 1'b0);

      // Word, byte and lane stores.
      access(1'b1, 1'b0, 32'd8, 32'h7FFF_FFFF, 2'b10, 1'b0);
      access(1'b0, 1'b1, 32'd8, 32'h0, 2'b10, 1'b0);
      access(1'b1, 1'b0, 32'd8, 32'h0000_0000, 2'b00, 1'b0);
      access(1'b0, 1'b1, 32'd8, 32'h0, 2'b10, 1'b0);
      access(1'b1, 1'b0, 32'd10, 32'h0000_00AB, 2'b00, 1'b0);
      access(1'b0, 1'b1, 32'd8, 32'h0, 2'b10, 1'b0);

      // Sign and zero extension.
      access(1'b1, 1'b0, 32'd20, 32'hAAAA_AAAA, 2'b10, 1'b0);
      access(1'b0, 1'b1, 32'd20, 32'h0, 2'b00, 1'b0);
      access(1'b0, 1'b1, 32'd20, 32'h0, 2'b00, 1'b1);
      access(1'b0, 1'b1, 32'd22, 32'h0, 2'b01, 1'b1);
      access(1'b0, 1'b1, 32'd22, 32'h0, 2'b01, 1'b0);

      // Read-before-write and address wrap.
      access(1'b1, 1'b1, 32'd20, 32'h1234_5678, 2'b10, 1'b0);
      access(1'b0, 1'b1, 32'd20, 32'h0, 2'b10, 1'b0);
      access(1'b0, 1'b1, 32'd20 + 32'd1024, 32'h0, 2'b10, 1'b0);

      // Reserved size behaves as a word.
      access(1'b1, 1'b0, 32'd40, 32'hCAFE_F00D, 2'b11, 1'b0);
      access(1'b0, 1'b1, 32'd40, 32'h0, 2'b11, 1'b0);

      // Misaligned accesses.
      access(1'b1, 1'b0, 32'd6, 32'hDEAD_BEEF, 2'b10, 1'b0);
      idle(2);
      check("misalign_hold", 32'(misalign), 32'(exp_mis));
      access(1'b0, 1'b1, 32'd4, 32'h0, 2'b10, 1'b0);
      access(1'b0, 1'b1, 32'd21, 32'h0, 2'b01, 1'b1);
      access(1'b0, 1'b1, 32'd23, 32'h0, 2'b00, 1'b1);

      // Randomized traffic over a small window with random upper address bits.
      for (int i = 0; i < 600; i++) begin
         w  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         a  = ($urandom() << 10) | 32'($urandom_range(0, 127));
         sz = 2'($urandom_range(0, 3));
         access(w, r, a, $urandom(), sz, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) idle(1);
      end

      // Reset in the middle of a read.
      access(1'b1, 1'b0, 32'd12, 32'h55AA_55AA, 2'b10, 1'b0);
      re   = 1'b1;
      ad   = 32'd12;
      size = 2'b10;
      @(posedge clk);
      #1;
      check("pre_reset_rvalid", 32'(rvalid), 32'h1);
      check("pre_reset_d_o", d_o, 32'h55AA_55AA);
      #1;
      rst_n = 1'b0;
      #1;
      re = 1'b0;
      check("midreset_rvalid", 32'(rvalid), 32'h0);
      check("midreset_d_o", d_o, 32'h0);
      check("midreset_busy", 32'(busy), 32'h1);
      check("midreset_misalign", 32'(misalign), 32'h0);
      exp_q.delete();

      run_clear("post");
      access(1'b0, 1'b1, 32'd12, 32'h0, 2'b10, 1'b0);
      access(1'b0, 1'b1, 32'd20, 32'h0, 2'b10, 1'b0);
      access(1'b0, 1'b1, 32'd8, 32'h0, 2'b10, 1'b0);

      idle(3);
      check("pending_reads", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
